expose_sequencer: RTL and testbench
===================================

Name: expose_sequencer

Overview:
Parametrised successor to the fixed 6-bit exposure counter. Runs one complete pixel exposure sequence per start request: pixel-reset phase, then exposure phase, then readout handshake. Lengths are latched per frame. Sits between the top-level frame controller and the pixel-array analog drivers (pix_reset, expose) and the readout/ADC block.

Parameters:
CNT_W, 8, width of exposure length and exposure counter (max exposure 2^CNT_W-1 cycles)
RST_W, 4, width of pixel-reset length and its counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request a new sequence; accepted only in IDLE
abort  in  1  cancel any sequence in progress
expose_cycles  in  CNT_W  exposure length N, sampled at start acceptance
pixreset_cycles  in  RST_W  pixel-reset length P, sampled at start acceptance
readout_ack  in  1  readout block has taken the frame
busy  out  1  high in any state except IDLE
pix_reset  out  1  pixel-reset drive, high exactly P cycles
expose  out  1  exposure drive, high exactly N cycles
expose_finished  out  1  level, high in DONE until ack
readout_req  out  1  level, high in DONE until ack
aborted  out  1  one-cycle pulse when an abort takes effect
expose_count  out  CNT_W  exposure cycles elapsed in current/last frame

Behaviour:
- Reset (async assert): state IDLE; all 1-bit outputs 0; expose_count 0; latched N, P = 0.
- States: IDLE, PIXRST, EXPOSE, DONE. All outputs registered, no combinational paths from inputs to outputs.
- IDLE: start=1 at edge k -> latch N, P; clear expose_count; at k: state PIXRST if P>0, else EXPOSE if N>0, else DONE. busy high from cycle after k.
- PIXRST: pix_reset=1 for exactly P consecutive cycles. Then EXPOSE (N>0) or DONE (N=0).
- EXPOSE: expose=1 for exactly N consecutive cycles. expose_count increments once per cycle while expose=1; ends equal to N. pix_reset and expose are never high in the same cycle, and there is no gap cycle between them.
- DONE: expose_finished=1 and readout_req=1. Held until readout_ack=1 is sampled. The next state is IDLE and both outputs drop in the same cycle.
- readout_ack outside DONE is ignored.
- N=0 and P=0: DONE is entered the cycle after start. Neither drive asserts; the frame still completes the handshake.
- Port changes after acceptance have no effect on the running frame.
- start while busy is ignored; it is not queued.
- abort=1 in any non-IDLE state: the next state is IDLE; pix_reset, expose, expose_finished and readout_req go to 0; aborted pulses 1 for one cycle.
- abort in IDLE: no effect, no pulse.
- abort and start in the same IDLE cycle: start wins.
- abort and readout_ack in the same DONE cycle: abort wins, and aborted pulses.
- expose_count holds its value in DONE and IDLE until the next accepted start.
- Counters never wrap. Maximum N = 2^CNT_W-1; the terminal compare is equality with the latched value.
- Reset mid-sequence: immediate return to reset values; no aborted pulse.

Optional Feature:
EXPOSE_REPEAT_EN: when defined, adds input port continuous (1 bit).
- If continuous=1 when readout_ack is accepted in DONE, the block skips IDLE and restarts directly in PIXRST/EXPOSE/DONE, using the same latched N, P rules. expose_count clears and busy stays high.
- continuous=0 at ack, or any abort, returns to IDLE as normal.
When undefined: port absent; every frame returns to IDLE.

Test Plan:
- Basic frame, CNT_W=8: P=3, N=5, start pulse, ack 2 cycles after readout_req -> pix_reset high 3 cycles, then expose high 5 cycles back-to-back; expose_count=5; readout_req held 2 cycles; busy low the cycle after ack.
- Zero lengths: P=0, N=0 -> readout_req the cycle after start; pix_reset/expose never high; expose_count=0.
- Max length: N=255, P=15 -> expose high exactly 255 cycles; expose_count=255, no wrap.
- Latch/ignore: change N from 5 to 9 and pulse start mid-EXPOSE -> expose still 5 cycles; second start not executed.
- Abort: abort on the 3rd expose cycle of N=10 -> expose low next cycle; aborted one-cycle pulse; IDLE; expose_count=3. Repeat with abort+ack together in DONE -> aborted pulse, no second frame. Async reset mid-PIXRST -> all outputs 0 immediately.
- EXPOSE_REPEAT_EN: continuous=1, P=2, N=4, ack three frames -> three consecutive pix_reset(2)/expose(4) bursts with busy never dropping; drop continuous before the third ack -> IDLE after it.

Source files
------------

// File: rtl/expose_sequencer_if.sv
// Control/drive bundle between the frame controller (master) and expose_sequencer (slave).
// EXPOSE_REPEAT_EN adds the continuous request input.
interface expose_sequencer_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RST_W = 4
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] expose_cycles;
  logic [RST_W-1:0] pixreset_cycles;
  logic             readout_ack;
`ifdef EXPOSE_REPEAT_EN
  logic             continuous;
`endif
  logic             busy;
  logic             pix_reset;
  logic             expose;
  logic             expose_finished;
  logic             readout_req;
  logic             aborted;
  logic [CNT_W-1:0] expose_count;

`ifdef EXPOSE_REPEAT_EN
  modport master (
    output start, abort, expose_cycles, pixreset_cycles, readout_ack, continuous,
    input  busy, pix_reset, expose, expose_finished, readout_req, aborted, expose_count
  );
  modport slave (
    input  start, abort, expose_cycles, pixreset_cycles, readout_ack, continuous,
    output busy, pix_reset, expose, expose_finished, readout_req, aborted, expose_count
  );
`else
  modport master (
    output start, abort, expose_cycles, pixreset_cycles, readout_ack,
    input  busy, pix_reset, expose, expose_finished, readout_req, aborted, expose_count
  );
  modport slave (
    input  start, abort, expose_cycles, pixreset_cycles, readout_ack,
    output busy, pix_reset, expose, expose_finished, readout_req, aborted, expose_count
  );
`endif
endinterface

// File: rtl/expose_sequencer.sv
// Pixel exposure sequencer: pixel-reset phase, exposure phase, then readout handshake.
// Optional EXPOSE_REPEAT_EN: restart a frame directly from DONE while continuous is high.
module expose_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RST_W = 4
) (
  input logic clk,
  input logic reset,
  expose_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PIXRST, EXPOSE, DONE} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] n_lat, n_lat_d;
  logic [RST_W-1:0] p_lat, p_lat_d;
  logic [CNT_W-1:0] exp_cnt, exp_cnt_d;
  logic [RST_W-1:0] rst_cnt, rst_cnt_d;
  logic             busy_d, pix_reset_d, expose_d, done_d, aborted_d;
  logic             repeat_c;

`ifdef EXPOSE_REPEAT_EN
  assign repeat_c = bus.continuous;
`else
  assign repeat_c = 1'b0;
`endif

  // Zero-length phases are skipped entirely.
  function automatic state_t first_state(input logic [RST_W-1:0] p, input logic [CNT_W-1:0] n);
    if (p != '0)      return PIXRST;
    else if (n != '0) return EXPOSE;
    else              return DONE;
  endfunction

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      n_lat               <= '0;
      p_lat               <= '0;
      exp_cnt             <= '0;
      rst_cnt             <= '0;
      bus.busy            <= 1'b0;
      bus.pix_reset       <= 1'b0;
      bus.expose          <= 1'b0;
      bus.expose_finished <= 1'b0;
      bus.readout_req     <= 1'b0;
      bus.aborted         <= 1'b0;
    end else begin
      state               <= state_d;
      n_lat               <= n_lat_d;
      p_lat               <= p_lat_d;
      exp_cnt             <= exp_cnt_d;
      rst_cnt             <= rst_cnt_d;
      bus.busy            <= busy_d;
      bus.pix_reset       <= pix_reset_d;
      bus.expose          <= expose_d;
      bus.expose_finished <= done_d;
      bus.readout_req     <= done_d;
      bus.aborted         <= aborted_d;
    end
  end

  assign bus.expose_count = exp_cnt;

  // Next state; counters hold the number of cycles already begun in the current phase
  always_comb begin
    state_d   = state;
    n_lat_d   = n_lat;
    p_lat_d   = p_lat;
    exp_cnt_d = exp_cnt;
    rst_cnt_d = rst_cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          n_lat_d   = bus.expose_cycles;
          p_lat_d   = bus.pixreset_cycles;
          state_d   = first_state(bus.pixreset_cycles, bus.expose_cycles);
          exp_cnt_d = (state_d == EXPOSE) ? CNT_W'(1) : '0;
          rst_cnt_d = RST_W'(1);
        end
      end
      PIXRST: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (rst_cnt == p_lat) begin
          state_d   = (n_lat != '0) ? EXPOSE : DONE;
          exp_cnt_d = (n_lat != '0) ? CNT_W'(1) : '0;
        end else begin
          rst_cnt_d = rst_cnt + RST_W'(1);
        end
      end
      EXPOSE: begin
        if (bus.abort)              state_d = IDLE;
        else if (exp_cnt == n_lat)  state_d = DONE;
        else                        exp_cnt_d = exp_cnt + CNT_W'(1);
      end
      DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.readout_ack) begin
          if (repeat_c) begin
            state_d   = first_state(p_lat, n_lat);
            exp_cnt_d = (state_d == EXPOSE) ? CNT_W'(1) : '0;
            rst_cnt_d = RST_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    busy_d      = (state_d != IDLE);
    pix_reset_d = (state_d == PIXRST);
    expose_d    = (state_d == EXPOSE);
    done_d      = (state_d == DONE);
    aborted_d   = bus.abort && (state != IDLE);
  end

endmodule

// File: tb/tb_expose_sequencer.sv
// Randomized scoreboard bench for expose_sequencer: frame-level expectations checked by a monitor.
module tb_expose_sequencer;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RST_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  expose_sequencer_if #(.CNT_W(CNT_W), .RST_W(RST_W)) bus ();
  expose_sequencer #(.CNT_W(CNT_W), .RST_W(RST_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit is_abort;
    int pix;
    int exp;
    int cnt;
    int pre;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   last_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a frame is P pixel-reset cycles, N exposure cycles, then DONE.
  // An abort during frame cycle a truncates the timeline at a.
  task automatic push_model(input int p, input int n, input int mode, input int a);
    exp_t e;
    if (mode == 1) begin
      e.is_abort = 1'b1;
      e.pix = (a < p) ? a : p;
      e.exp = (a > p) ? a - p : 0;
      e.cnt = e.exp;
      e.pre = a;
      sb.push_back(e);
      last_cnt = e.cnt;
    end else begin
      e.is_abort = 1'b0;
      e.pix = p;
      e.exp = n;
      e.cnt = n;
      e.pre = p + n;
      sb.push_back(e);
      if (mode == 2) begin
        e.is_abort = 1'b1;
        sb.push_back(e);
      end
      last_cnt = n;
    end
  endtask

  // Monitor: accumulates per-frame observations and compares at each frame event
  int   m_pix, m_exp, m_pre;
  logic prev_busy, prev_rr;

  task automatic handle_event(input bit is_abort);
    exp_t e;
    if (sb.size() == 0) begin
      check(is_abort ? "unexpected_aborted" : "unexpected_readout_req", 1, 0);
    end else begin
      e = sb.pop_front();
      check("event_is_abort", int'(is_abort), int'(e.is_abort));
      check("pix_reset_cycles", m_pix, e.pix);
      check("expose_cycles", m_exp, e.exp);
      check("expose_count", int'(bus.expose_count), e.cnt);
      check("busy_cycles_before_done", m_pre, e.pre);
      if (is_abort) check("busy_in_aborted_cycle", int'(bus.busy), 0);
      else          check("expose_finished_in_done", int'(bus.expose_finished), 1);
    end
  endtask

  initial begin
    m_pix = 0; m_exp = 0; m_pre = 0;
    prev_busy = 1'b0; prev_rr = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_pix = 0; m_exp = 0; m_pre = 0;
        prev_busy = 1'b0; prev_rr = 1'b0;
        continue;
      end
      if ((!prev_busy && bus.busy) || (prev_rr && !bus.readout_req && bus.busy)) begin
        m_pix = 0; m_exp = 0; m_pre = 0;
      end
      m_pix += int'(bus.pix_reset);
      m_exp += int'(bus.expose);
      if (bus.busy && !bus.readout_req) m_pre++;
      if (bus.pix_reset || bus.expose) check("drive_overlap", int'(bus.pix_reset && bus.expose), 0);
      if (bus.readout_req && !prev_rr) handle_event(1'b0);
      if (bus.aborted) handle_event(1'b1);
      prev_busy = bus.busy;
      prev_rr   = bus.readout_req;
    end
  end

  task automatic wait_req();
    int w = 0;
    while (!bus.readout_req && w < 8) begin
      step();
      w++;
    end
    check("readout_req_latency", w, 0);
  endtask

  // mode 0: normal, 1: abort in frame cycle a, 2: abort together with ack in DONE.
  // noise: frame cycle with a stray start and readout_ack (0 = none).
  task automatic run_frame(input int p, input int n, input int mode, input int a,
                           input int noise, input int dly, input bit abort_at_start);
    int last;
    bus.start           = 1'b1;
    bus.abort           = abort_at_start;
    bus.pixreset_cycles = RST_W'(p);
    bus.expose_cycles   = CNT_W'(n);
    push_model(p, n, mode, a);
    step();
    bus.start           = 1'b0;
    bus.abort           = 1'b0;
    bus.pixreset_cycles = RST_W'($urandom);
    bus.expose_cycles   = CNT_W'($urandom);
    last = (mode == 1) ? a : p + n;
    for (int c = 1; c <= last; c++) begin
      bus.start       = (c == noise);
      bus.readout_ack = (c == noise);
      bus.abort       = (mode == 1 && c == a);
      step();
      bus.start       = 1'b0;
      bus.readout_ack = 1'b0;
      bus.abort       = 1'b0;
    end
    if (mode != 1) begin
      wait_req();
      repeat (dly) step();
      bus.readout_ack = 1'b1;
      bus.abort       = (mode == 2);
      step();
      bus.readout_ack = 1'b0;
      bus.abort       = 1'b0;
      check("busy_after_ack", int'(bus.busy), 0);
      check("readout_req_after_ack", int'(bus.readout_req), 0);
    end
  endtask

  task automatic idle_gap();
    int g = int'($urandom_range(0, 2));
    for (int i = 0; i < g; i++) begin
      bus.abort = ($urandom_range(0, 1) == 1);
      step();
      bus.abort = 1'b0;
    end
    check("expose_count_hold_idle", int'(bus.expose_count), last_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int p, n, mode, a, noise, sel;
    reset               = 1'b1;
    bus.start           = 1'b0;
    bus.abort           = 1'b0;
    bus.readout_ack     = 1'b0;
    bus.expose_cycles   = '0;
    bus.pixreset_cycles = '0;
`ifdef EXPOSE_REPEAT_EN
    bus.continuous      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_pix_reset", int'(bus.pix_reset), 0);
    check("reset_expose", int'(bus.expose), 0);
    check("reset_expose_finished", int'(bus.expose_finished), 0);
    check("reset_readout_req", int'(bus.readout_req), 0);
    check("reset_aborted", int'(bus.aborted), 0);
    check("reset_expose_count", int'(bus.expose_count), 0);
    reset = 1'b0;
    step();

    // Directed frames
    run_frame(3, 5, 0, 0, 0, 1, 1'b0);    idle_gap();
    run_frame(0, 0, 0, 0, 0, 0, 1'b0);    idle_gap();
    run_frame(15, 255, 0, 0, 0, 2, 1'b0); idle_gap();
    run_frame(2, 5, 0, 0, 4, 1, 1'b0);    idle_gap();
    run_frame(2, 10, 1, 5, 0, 0, 1'b0);   idle_gap();
    run_frame(3, 4, 2, 0, 0, 1, 1'b0);    idle_gap();
    run_frame(1, 0, 0, 0, 0, 0, 1'b1);    idle_gap();

    // Asynchronous reset in the middle of the pixel-reset phase
    bus.start = 1'b1; bus.pixreset_cycles = RST_W'(10); bus.expose_cycles = CNT_W'(5);
    step();
    bus.start = 1'b0;
    step(); step();
    check("pix_reset_before_reset", int'(bus.pix_reset), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pix_reset", int'(bus.pix_reset), 0);
    check("async_reset_busy", int'(bus.busy), 0);
    check("async_reset_aborted", int'(bus.aborted), 0);
    check("async_reset_expose_count", int'(bus.expose_count), 0);
    step();
    reset = 1'b0;
    last_cnt = 0;
    step();

`ifdef EXPOSE_REPEAT_EN
    // Continuous frames: busy must not drop between them
    bus.continuous = 1'b1;
    bus.start = 1'b1; bus.pixreset_cycles = RST_W'(2); bus.expose_cycles = CNT_W'(4);
    for (int f = 0; f < 3; f++) push_model(2, 4, 0, 0);
    step();
    bus.start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      repeat (6) step();
      wait_req();
      step();
      if (f == 2) bus.continuous = 1'b0;
      bus.readout_ack = 1'b1;
      step();
      bus.readout_ack = 1'b0;
      check("continuous_busy_after_ack", int'(bus.busy), (f < 2) ? 1 : 0);
      check("continuous_req_after_ack", int'(bus.readout_req), 0);
    end
    idle_gap();
`endif

    // Randomized frames
    for (int i = 0; i < 30; i++) begin
      p   = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 3));
      n   = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(1, 40));
      sel = int'($urandom_range(0, 3));
      mode = (sel == 2) ? ((p + n > 0) ? 1 : 0) : (sel == 3) ? 2 : 0;
      a = (mode == 1) ? int'($urandom_range(1, p + n)) : 0;
      noise = 0;
      if ($urandom_range(0, 1) == 1) begin
        if (mode == 1 && a > 1)      noise = int'($urandom_range(1, a - 1));
        else if (mode != 1 && p + n > 0) noise = int'($urandom_range(1, p + n));
      end
      run_frame(p, n, mode, a, noise, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      idle_gap();
    end

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);
    check("final_busy", int'(bus.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
